pipeline_control: RTL and testbench
===================================

Name: pipeline_control

Overview:
- Consumer of the hazard detector's load_hazard and branch_hazard outputs.
- Turns hazard, trap and memory-wait conditions into per-register enable and flush strobes for the 5-stage pipeline (PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Owns the instruction-fetch request/response handshake: one outstanding fetch at a time, with kill of stale responses after a redirect.

Parameters:
- RESET_FLUSH_CYCLES, 2: cycles the pipeline is held flushed after reset release; must be >= 1.
- CNT_W, 32: width of the performance counters (only used when the optional feature is enabled).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- load_hazard  in  1  load/CSR-use hazard in ID
- branch_hazard  in  1  taken branch/jump resolved in MEM
- trap_req  in  1  exception/interrupt taken in MEM
- dmem_busy  in  1  data access in MEM not complete
- imem_req_valid  out  1  fetch request at current PC
- imem_req_ready  in  1  imem accepts the request
- imem_rvalid  in  1  fetch response valid; held by imem until accepted
- imem_rready  out  1  response accepted this cycle
- pc_en  out  1  PC register update (next-PC or redirect target)
- if_id_en, id_exe_en, exe_mem_en, mem_wb_en  out  1 each  pipeline register enables
- if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush  out  1 each  load a bubble; flush overrides enable

Behaviour:
- Clock and reset: one clock `clk`; asynchronous, active-high reset `reset`.
- Reset values:
  - FSM = INIT; counter = RESET_FLUSH_CYCLES-1.
  - All four flushes = 1; all enables = 0.
  - pc_en, imem_req_valid and imem_rready = 0.
  - Reset mid-operation: any outstanding fetch is abandoned. Imem is reset by the same reset.
- FSM states:
  - INIT: all flushes = 1, no requests. Counter decrements each cycle; at 0, go to IDLE.
  - IDLE: no fetch outstanding.
  - WAIT: one request accepted, response pending.
  - KILL: a pending response is stale.
- Outputs are combinational from state plus inputs. Conditions are evaluated in priority order; the first match wins.
- 1. freeze = dmem_busy (outside INIT):
  - All enables = 0, all flushes = 0, pc_en = 0.
  - imem_req_valid = 0, imem_rready = 0.
  - State holds. Hazard inputs are ignored; they persist because the registers are frozen.
- 2. redirect = branch_hazard | trap_req:
  - pc_en = 1 (datapath loads the target).
  - if_id_flush, id_exe_flush, exe_mem_flush = 1; mem_wb_en = 1.
  - mem_wb_flush = trap_req (the trapping instruction does not retire).
  - imem_req_valid = 0.
  - imem_rready = 1 if state is WAIT or KILL; a response arriving this cycle is discarded.
  - Transitions: WAIT with rvalid -> IDLE; WAIT without rvalid -> KILL; IDLE -> IDLE; KILL -> KILL (or IDLE if rvalid).
- 3. load_hazard:
  - pc_en = 0, if_id_en = 0, id_exe_flush = 1; exe_mem_en = mem_wb_en = 1.
  - imem_req_valid = 0, imem_rready = 0. State holds.
- 4. normal:
  - id_exe_en = exe_mem_en = mem_wb_en = 1.
  - IDLE: imem_req_valid = 1. pc_en = imem_req_ready (PC advances on request acceptance). Accepted -> WAIT. if_id_flush = 1.
  - WAIT: imem_rready = 1. If rvalid: if_id_en = 1, and a new request is issued the same cycle; accepted -> stay WAIT, else -> IDLE. If no rvalid: if_id_flush = 1 (bubble).
  - KILL: imem_rready = 1, if_id_flush = 1. rvalid -> IDLE (response dropped).
- Handshake rules:
  - At most one outstanding fetch.
  - imem_req_valid, once asserted in IDLE, may drop only on freeze, redirect or load_hazard.
  - A response is never accepted while IF/ID is blocked.

Optional Feature:
- Macro PIPE_PERF_CNT_EN adds three CNT_W-bit outputs:
  - stall_cycles: increments on freeze or load_hazard cycles.
  - redirect_count: increments per redirect cycle.
  - killed_fetches: increments per discarded response.
- Counters reset to 0 and wrap modulo 2^CNT_W.
- Without the macro these ports and their logic do not exist.

Decomposition:
- Shared package `pipeline_ctrl_pkg` holds:
  - fetch_state_t enum (INIT, IDLE, WAIT, KILL).
  - pipe_ctrl_t struct bundling the enable/flush strobes.
  - Default RESET_FLUSH_CYCLES constant.
- One natural sub-module: fetch_handshake_fsm (state register, kill tracking, imem handshake). The top level does the priority decode.

Test Plan:
- Reset release with RESET_FLUSH_CYCLES=2 -> flushes stay 1 for 2 cycles. imem_req_valid=1 on the 3rd cycle; pc_en=1 when imem_req_ready=1.
- Back-to-back fetch with 1-cycle imem latency, no hazards -> if_id_en=1 every cycle after the first response; PC advances once per cycle.
- load_hazard for 1 cycle while in WAIT with rvalid=1 -> imem_rready=0, if_id_en=0, id_exe_flush=1. Response accepted the next cycle, not lost.
- branch_hazard in WAIT with rvalid=0, response 3 cycles later -> state KILL, if_id_flush=1 for 3 cycles. Response dropped; return to IDLE, then request at the new PC.
- dmem_busy held 4 cycles with load_hazard and branch_hazard both high -> all enables/flushes 0 for 4 cycles. On the 5th cycle the redirect wins (flushes asserted).
- trap_req with branch_hazard simultaneously -> mem_wb_flush=1 and redirect flushes. With PIPE_PERF_CNT_EN, redirect_count increments by 1.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline control block.
package pipeline_ctrl_pkg;

  localparam int unsigned DefaultResetFlushCycles = 2;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StWait,
    StKill
  } fetch_state_t;

  typedef struct packed {
    logic if_id_en;
    logic id_exe_en;
    logic exe_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_exe_flush;
    logic exe_mem_flush;
    logic mem_wb_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CtrlInit = '{
    if_id_flush: 1'b1, id_exe_flush: 1'b1, exe_mem_flush: 1'b1, mem_wb_flush: 1'b1,
    default: 1'b0
  };

endpackage

// File: rtl/fetch_handshake_fsm.sv
// Fetch state register, post-reset flush counter, stale-response kill tracking and the
// imem request/response handshake.
module fetch_handshake_fsm
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned RESET_FLUSH_CYCLES = DefaultResetFlushCycles
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         freeze,
  input  logic         redirect,
  input  logic         stall,
  input  logic         imem_req_ready,
  input  logic         imem_rvalid,
  output fetch_state_t state,
  output logic         imem_req_valid,
  output logic         imem_rready
);

  localparam int unsigned CntW = (RESET_FLUSH_CYCLES > 1) ? $clog2(RESET_FLUSH_CYCLES) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(RESET_FLUSH_CYCLES - 1);

  fetch_state_t    state_q;
  logic [CntW-1:0] cnt_q;
  logic            active;
  logic            pending;

  assign state   = state_q;
  assign active  = (state_q != StInit) && !freeze;
  assign pending = (state_q == StWait) || (state_q == StKill);

  // A redirect still drains a pending response so it can be discarded this cycle.
  always_comb begin
    imem_rready    = active && pending && (redirect || !stall);
    imem_req_valid = active && !redirect && !stall &&
                     ((state_q == StIdle) || ((state_q == StWait) && imem_rvalid));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StInit;
      cnt_q   <= CntInit;
    end else if (state_q == StInit) begin
      if (cnt_q == '0) begin
        state_q <= StIdle;
      end else begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end else if (active && (redirect || !stall)) begin
      unique case (state_q)
        StIdle: begin
          if (!redirect && imem_req_ready) state_q <= StWait;
        end
        StWait: begin
          if (redirect) begin
            state_q <= imem_rvalid ? StIdle : StKill;
          end else if (imem_rvalid && !imem_req_ready) begin
            state_q <= StIdle;
          end
        end
        StKill: begin
          if (imem_rvalid) state_q <= StIdle;
        end
        default: state_q <= StInit;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_control.sv
// Priority decode of freeze/redirect/load-hazard into pipeline enables and flushes.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_control
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned RESET_FLUSH_CYCLES = DefaultResetFlushCycles,
  parameter int unsigned CNT_W              = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_hazard,
  input  logic             branch_hazard,
  input  logic             trap_req,
  input  logic             dmem_busy,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  input  logic             imem_rvalid,
  output logic             imem_rready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_exe_en,
  output logic             exe_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             exe_mem_flush,
  output logic             mem_wb_flush
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] redirect_count,
  output logic [CNT_W-1:0] killed_fetches
`endif
);

  if (RESET_FLUSH_CYCLES < 1 || CNT_W < 1) begin : g_bad_param
    $error("pipeline_control: RESET_FLUSH_CYCLES and CNT_W must be >= 1");
  end

  fetch_state_t state;
  pipe_ctrl_t   ctrl;
  logic         redirect;
  logic         resp_take;

  assign redirect  = branch_hazard | trap_req;
  assign resp_take = (state == StWait) && imem_rvalid;

  fetch_handshake_fsm #(
    .RESET_FLUSH_CYCLES(RESET_FLUSH_CYCLES)
  ) u_fetch_fsm (
    .clk           (clk),
    .reset         (reset),
    .freeze        (dmem_busy),
    .redirect      (redirect),
    .stall         (load_hazard),
    .imem_req_ready(imem_req_ready),
    .imem_rvalid   (imem_rvalid),
    .state         (state),
    .imem_req_valid(imem_req_valid),
    .imem_rready   (imem_rready)
  );

  always_comb begin
    ctrl  = '0;
    pc_en = 1'b0;
    if (state == StInit) begin
      ctrl = CtrlInit;
    end else if (dmem_busy) begin
      ctrl = '0;
    end else if (redirect) begin
      pc_en              = 1'b1;
      ctrl.if_id_flush   = 1'b1;
      ctrl.id_exe_flush  = 1'b1;
      ctrl.exe_mem_flush = 1'b1;
      ctrl.mem_wb_en     = 1'b1;
      ctrl.mem_wb_flush  = trap_req;
    end else if (load_hazard) begin
      ctrl.id_exe_flush = 1'b1;
      ctrl.exe_mem_en   = 1'b1;
      ctrl.mem_wb_en    = 1'b1;
    end else begin
      ctrl.id_exe_en   = 1'b1;
      ctrl.exe_mem_en  = 1'b1;
      ctrl.mem_wb_en   = 1'b1;
      ctrl.if_id_en    = resp_take;
      ctrl.if_id_flush = !resp_take;
      pc_en            = imem_req_valid && imem_req_ready;
    end
  end

  assign if_id_en      = ctrl.if_id_en;
  assign id_exe_en     = ctrl.id_exe_en;
  assign exe_mem_en    = ctrl.exe_mem_en;
  assign mem_wb_en     = ctrl.mem_wb_en;
  assign if_id_flush   = ctrl.if_id_flush;
  assign id_exe_flush  = ctrl.id_exe_flush;
  assign exe_mem_flush = ctrl.exe_mem_flush;
  assign mem_wb_flush  = ctrl.mem_wb_flush;

`ifdef PIPE_PERF_CNT_EN
  logic active;
  logic killed;

  assign active = (state != StInit);
  // imem_rready is already low in INIT and on freeze, so no extra gating is needed.
  assign killed = imem_rvalid && imem_rready && (redirect || (state == StKill));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
      killed_fetches <= '0;
    end else begin
      if (active && (dmem_busy || (load_hazard && !redirect))) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (active && !dmem_busy && redirect) begin
        redirect_count <= redirect_count + CNT_W'(1);
      end
      if (killed) begin
        killed_fetches <= killed_fetches + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Table-driven bench for pipeline_control: each vector drives one cycle of inputs and
// checks the combinational strobes through a small expected-value queue.
module tb_pipeline_control;
  import pipeline_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_hazard = 1'b0, branch_hazard = 1'b0, trap_req = 1'b0, dmem_busy = 1'b0;
  logic imem_req_ready = 1'b0, imem_rvalid = 1'b0;
  logic imem_req_valid, imem_rready, pc_en;
  logic if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
  logic if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, redirect_count, killed_fetches;
`endif

  always #5 clk = ~clk;

  pipeline_control #(
    .RESET_FLUSH_CYCLES(2),
    .CNT_W             (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .load_hazard   (load_hazard),
    .branch_hazard (branch_hazard),
    .trap_req      (trap_req),
    .dmem_busy     (dmem_busy),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rready   (imem_rready),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_exe_en     (id_exe_en),
    .exe_mem_en    (exe_mem_en),
    .mem_wb_en     (mem_wb_en),
    .if_id_flush   (if_id_flush),
    .id_exe_flush  (id_exe_flush),
    .exe_mem_flush (exe_mem_flush),
    .mem_wb_flush  (mem_wb_flush)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles),
    .redirect_count(redirect_count),
    .killed_fetches(killed_fetches)
`endif
  );

  // {pc_en, req_valid, rready, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
  //  if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush}
  logic [10:0] act;
  assign act = {pc_en, imem_req_valid, imem_rready, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
                if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush};

  localparam logic [10:0] E_INIT  = 11'b000_0000_1111;
  localparam logic [10:0] E_FRZ   = 11'b000_0000_0000;
  localparam logic [10:0] E_IDLE0 = 11'b010_0111_1000;
  localparam logic [10:0] E_IDLE1 = 11'b110_0111_1000;
  localparam logic [10:0] E_WV0   = 11'b011_1111_0000;
  localparam logic [10:0] E_WV1   = 11'b111_1111_0000;
  localparam logic [10:0] E_WN    = 11'b001_0111_1000;
  localparam logic [10:0] E_KILL  = 11'b001_0111_1000;
  localparam logic [10:0] E_LH    = 11'b000_0011_0100;
  localparam logic [10:0] E_RDIT  = 11'b100_0001_1111;
  localparam logic [10:0] E_RDP   = 11'b101_0001_1110;
  localparam logic [10:0] E_RDPT  = 11'b101_0001_1111;

  // Inputs packed as {load_hazard, branch_hazard, trap_req, dmem_busy, req_ready, rvalid}.
  typedef struct {
    string       name;
    logic [5:0]  in;
    logic [10:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [10:0] sb_q[$];
  string       sb_name[$];
  int          n_vec = 0;
  int          n_fail = 0;

  task automatic add(input string name, input logic [5:0] in, input logic [10:0] exp);
    vec_t v;
    v.name = name;
    v.in   = in;
    v.exp  = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic step(input string name, input logic [5:0] in, input logic [10:0] exp);
    {load_hazard, branch_hazard, trap_req, dmem_busy, imem_req_ready, imem_rvalid} = in;
    sb_q.push_back(exp);
    sb_name.push_back(name);
    @(negedge clk);
    check(sb_name.pop_front(), {21'b0, act}, {21'b0, sb_q.pop_front()});
    @(posedge clk);
    #1;
  endtask

  initial begin
    add("init0",        6'b000000, E_INIT);
    add("init1_busy",   6'b000100, E_INIT);
    add("idle_noready", 6'b000000, E_IDLE0);
    add("idle_req",     6'b000010, E_IDLE1);
    add("b2b_0",        6'b000011, E_WV1);
    add("b2b_1",        6'b000011, E_WV1);
    add("lh_wait_rv",   6'b100011, E_LH);
    add("resp_after_lh",6'b000001, E_WV0);
    add("idle_req2",    6'b000010, E_IDLE1);
    add("br_wait_norv", 6'b010000, E_RDP);
    add("kill_0",       6'b000000, E_KILL);
    add("kill_1",       6'b000000, E_KILL);
    add("kill_drop",    6'b000001, E_KILL);
    add("idle_req3",    6'b000010, E_IDLE1);
    for (int i = 0; i < 4; i++) add($sformatf("frz_%0d", i), 6'b110101, E_FRZ);
    add("frz_release",  6'b110000, E_RDP);
    add("trap_br_kill", 6'b011001, E_RDPT);
    add("trap_br_idle", 6'b011000, E_RDIT);
    add("lh_idle",      6'b100010, E_LH);
    add("frz_idle",     6'b000100, E_FRZ);
    add("idle_req4",    6'b000010, E_IDLE1);
    add("wait_norv",    6'b000000, E_WN);
    add("br_wait_rv",   6'b010001, E_RDP);
    add("idle_end",     6'b000000, E_IDLE0);

    #3;
    check("reset", {21'b0, act}, {21'b0, E_INIT});
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (tbl[i]) step(tbl[i].name, tbl[i].in, tbl[i].exp);

`ifdef PIPE_PERF_CNT_EN
    check("redirect_count", redirect_count, 32'd5);
    check("killed_fetches", killed_fetches, 32'd3);
    check("stall_cycles", stall_cycles, 32'd7);
`endif

    // Reset asserted while a fetch is outstanding.
    step("idle_req5", 6'b000010, E_IDLE1);
    {load_hazard, branch_hazard, trap_req, dmem_busy, imem_req_ready, imem_rvalid} = 6'b000000;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", {21'b0, act}, {21'b0, E_INIT});
`ifdef PIPE_PERF_CNT_EN
    check("cnt_reset", redirect_count | killed_fetches | stall_cycles, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("rst_init0", 6'b000010, E_INIT);
    step("rst_init1", 6'b000011, E_INIT);
    step("rst_idle",  6'b000010, E_IDLE1);
    step("rst_wait",  6'b000001, E_WV0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
